// File: rtl/spm_dma.sv
// spm_dma -- port-B DMA master for the scratch-pad memory.
//
// Copies (read word, write word) or fills blocks of SPM words through port B
// of the dual-port RAM. A one-cycle start in IDLE latches the command, a
// one-cycle done pulse reports completion, and abort drops back to IDLE
// without a done pulse.
//
// Build option: define SPM_DMA_FILL_EN to enable fill mode. Without it the
// FILL state does not exist, mode and fill_data are ignored, and every
// command is a copy.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   start      command strobe (accepted only in IDLE)
//   mode       0 = copy, 1 = fill
//   src, dst   source / destination word addresses
//   len        word count, ADDR_W+1 bits, clamped to 2^ADDR_W
//   fill_data  fill pattern
//   abort      cancel the running transfer
//   busy       transfer in progress
//   done       one-cycle completion pulse
//   addrb      RAM port-B address
//   dinb       RAM port-B write data
//   web        RAM port-B write enable
//   doutb      RAM port-B read data (one cycle after address)
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | waiting for start
// RD    | present read address src+i
// WR    | write doutb to dst+i, advance i
// FILL  | write fill pattern to dst+i, advance i
// DONE  | one-cycle completion pulse
module spm_dma #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dinb,
  output logic              web,
  input  logic [DATA_W-1:0] doutb
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
`ifdef SPM_DMA_FILL_EN
    FILL,
`endif
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q, addr_hold;
  logic [ADDR_W:0]   len_q, idx, idx_inc, eff_len;
  logic              last;

  // len[ADDR_W] set means "whole memory" regardless of the low bits.
  assign eff_len = len[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : len;
  assign idx_inc = idx + 1'b1;
  assign last    = (idx_inc == len_q);

`ifdef SPM_DMA_FILL_EN
  logic [DATA_W-1:0] fill_q;

  always_ff @(posedge clk) begin
    if (!reset)
      fill_q <= '0;
    else if (state == IDLE && start)
      fill_q <= fill_data;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode, fill_data};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx       <= '0;
      addr_hold <= '0;
    end else begin
      state     <= state_nxt;
      addr_hold <= addrb;
      if (state == IDLE && start) begin
        src_q <= src;
        dst_q <= dst;
        len_q <= eff_len;
        idx   <= '0;
      end else if (web) begin
        idx <= idx_inc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    web       = 1'b0;
    dinb      = '0;
    addrb     = addr_hold;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (eff_len == '0)
            state_nxt = DONE;
`ifdef SPM_DMA_FILL_EN
          else if (mode)
            state_nxt = FILL;
`endif
          else
            state_nxt = RD;
        end
      end
      RD: begin
        addrb     = src_q + idx[ADDR_W-1:0];
        state_nxt = abort ? IDLE : WR;
      end
      WR: begin
        addrb     = dst_q + idx[ADDR_W-1:0];
        dinb      = doutb;
        web       = 1'b1;
        state_nxt = abort ? IDLE : (last ? DONE : RD);
      end
`ifdef SPM_DMA_FILL_EN
      FILL: begin
        addrb     = dst_q + idx[ADDR_W-1:0];
        dinb      = fill_q;
        web       = 1'b1;
        state_nxt = abort ? IDLE : (last ? DONE : FILL);
      end
`endif
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/spm_dma.md
# spm_dma

Port-B master for the scratch-pad memory: a small DMA engine that copies or fills blocks of words inside the SPM through the dual-port RAM's second port while the CPU keeps using port A. It accepts a one-cycle start command with source, destination and length, then sequences registered RAM reads and writes and reports completion with a one-cycle pulse. It sits between the SPM control registers (command side) and port B of the SPM dual-port RAM (memory side).

## Interface
- ADDR_W, 12, SPM word-address width (matches SPM depth 4096).
- DATA_W, 32, word width.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src  in  ADDR_W  source word address (copy).
- dst  in  ADDR_W  destination word address.
- len  in  ADDR_W+1  word count; 0 allowed.
- fill_data  in  DATA_W  fill pattern (fill mode).
- abort  in  1  cancel current transfer.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- addrb  out  ADDR_W  RAM port-B address.
- dinb  out  DATA_W  RAM port-B write data.
- web  out  1  RAM port-B write enable, active high.
- doutb  in  DATA_W  RAM port-B read data, valid one cycle after address.

## Operation
- States: IDLE, RD, WR, FILL, DONE.
- IDLE: start=1 latches src, dst, len, mode, fill_data; effective length L = len clamped to 2^ADDR_W (len[ADDR_W]=1 → L = 2^ADDR_W). L=0 → DONE; mode=1 → FILL; else RD.
- RD: addrb = src+i, web=0; → WR.
- WR: addrb = dst+i, dinb = doutb (combinational pass-through), web=1; i++; i==L → DONE else RD.
- FILL: addrb = dst+i, dinb = latched fill_data, web=1; i++; i==L → DONE.
- DONE: done=1, busy=0, web=0; → IDLE.
- Address arithmetic modulo 2^ADDR_W; wrap 4095 → 0 silently.
- Transfer strictly ascending; overlapping copy with dst > src replicates the source pattern (defined behaviour, not an error).
- start while not IDLE: ignored. start in DONE: ignored.
- abort=1 in RD/WR/FILL: the access presented that cycle completes; next state IDLE, no done pulse. abort in IDLE/DONE: no effect.
- Port-A writes to the address being read are forwarded by the RAM; engine reads whatever doutb returns.
- Outside WR/FILL: web=0, dinb=0, addrb holds last value (0 after reset).

## Timing
- Reset (reset=0 at a rising edge): state IDLE, busy=0, done=0, web=0, addrb=0, dinb=0, i=0. Applies mid-transfer; any write presented in that cycle is not guaranteed.
- start accepted at edge E0; busy=1 from the cycle after E0.
- Copy: word i read presented cycle 1+2i, written cycle 2+2i; done in cycle 2L+1; busy=0 from that cycle.
- Fill: word i written cycle 1+i; done in cycle L+1.
- L=0: done in cycle 1, no RAM access.
- Throughput: copy 2 cycles/word, fill 1 cycle/word.
- Next start accepted earliest in cycle after done.

## Configuration
- SPM_DMA_FILL_EN defined: fill mode available as above.
- Not defined: FILL state absent, mode and fill_data ignored, every command is a copy.

## Test plan
- Copy: preload mem[0x010..0x013]=A0..A3; start src=0x010 dst=0x100 len=4 → web high in cycles 2,4,6,8 at 0x100..0x103 with A0..A3; done in cycle 9; busy low same cycle.
- Fill (SPM_DMA_FILL_EN): dst=0x200 len=3 fill_data=0xDEADBEEF → writes cycles 1..3, done cycle 4; mem[0x200..0x202]=0xDEADBEEF; with macro undefined, same command performs copy from src.
- Wrap: copy src=0xFFE dst=0x000 len=3 → reads 0xFFE,0xFFF,0x000; writes 0x000..0x002; mem[0x002] gets original mem[0x000] written at 0x000 in first step? no: gets value read at cycle 5 (new mem[0x000]=old mem[0xFFE]).
- len=0 and len=0x1FFF: done in cycle 1 with no web; 0x1FFF clamps to 4096 words, done cycle 8193.
- Abort: copy len=8, abort in cycle 5 → write of word 1 in cycle 4 kept, cycle 5 read only, idle in cycle 6, done never pulses; start during busy ignored.
- Reset mid-copy (cycle 3) → cycle 4 busy=0, web=0, addrb=0; new start afterwards runs normally.
